// File: rtl/multi_bit_demultiplexer_4way_buffered.sv
// -----------------------------------------------------------------------------
// multi_bit_demultiplexer_4way_buffered
//
// Routes one WIDTH-bit word into one of four buffered output lanes (A/B/C/D)
// chosen by a 2-bit select. Each lane owns a single-entry holding register
// with a valid/ready handshake toward its consumer. The producer is stalled
// only when the lane it targets is still occupied and not draining this cycle.
//
// Ports:
//   clk                    rising-edge clock
//   reset_n                asynchronous active-low reset
//   in      [WIDTH-1:0]    data word to route
//   S       [1:0]          lane select: 00=A, 01=B, 10=C, 11=D
//   in_valid               producer presents in/S this cycle
//   in_ready               block accepts in/S this cycle (combinational)
//   A..D    [WIDTH-1:0]    lane holding registers
//   A_valid..D_valid       lane holds an undelivered word
//   A_ready..D_ready       consumer takes the lane word this cycle
//   busy                   OR of all lane valid flags
//   count   [COUNT_WIDTH-1:0] accepted words, wrapping modulo 2^COUNT_WIDTH
// -----------------------------------------------------------------------------
module multi_bit_demultiplexer_4way_buffered #(
    parameter int WIDTH       = 1,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       in,
    input  logic [1:0]             S,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       A,
    output logic [WIDTH-1:0]       B,
    output logic [WIDTH-1:0]       C,
    output logic [WIDTH-1:0]       D,
    output logic                   A_valid,
    output logic                   B_valid,
    output logic                   C_valid,
    output logic                   D_valid,
    input  logic                   A_ready,
    input  logic                   B_ready,
    input  logic                   C_ready,
    input  logic                   D_ready,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] count
);

    logic [WIDTH-1:0]       laneData_q [4];
    logic [WIDTH-1:0]       laneData_d [4];
    logic [3:0]             laneValid_q;
    logic [3:0]             laneValid_d;
    logic [3:0]             laneReady;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   accept;

    assign laneReady = {D_ready, C_ready, B_ready, A_ready};

    // A lane can take a new word when it is empty or is being drained on
    // this same edge; depends only on S, lane flags and consumer readies.
    assign in_ready = !laneValid_q[S] || laneReady[S];
    assign accept   = in_valid && in_ready;

    // Next-state for every lane: a load into the lane wins over a drain so a
    // lane can be emptied and refilled on one edge. Data only moves on a load.
    always_comb begin
        laneValid_d = laneValid_q;
        for (int i = 0; i < 4; i++) begin
            laneData_d[i] = laneData_q[i];
            if (accept && (S == 2'(i))) begin
                laneValid_d[i] = 1'b1;
                laneData_d[i]  = in;
            end else if (laneValid_q[i] && laneReady[i]) begin
                laneValid_d[i] = 1'b0;
            end
        end
        count_d = accept ? count_q + 1'b1 : count_q;
    end

    // Lane registers and transfer counter; reset clears everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                laneData_q[i] <= '0;
            end
            laneValid_q <= '0;
            count_q     <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                laneData_q[i] <= laneData_d[i];
            end
            laneValid_q <= laneValid_d;
            count_q     <= count_d;
        end
    end

    assign A       = laneData_q[0];
    assign B       = laneData_q[1];
    assign C       = laneData_q[2];
    assign D       = laneData_q[3];
    assign A_valid = laneValid_q[0];
    assign B_valid = laneValid_q[1];
    assign C_valid = laneValid_q[2];
    assign D_valid = laneValid_q[3];
    assign busy    = |laneValid_q;
    assign count   = count_q;

endmodule
